stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Top-level sequencer for the stopwatch. It takes the two raw pushbuttons (start/stop, lap/clear), synchronises, debounces and edge-detects them, and runs the IDLE/RUN/PAUSE/LAP state machine. It drives the time-base tick, the clear pulse and the display-freeze control for the downstream time-counter and display datapath.

Parameters:
DB_CYC, 500000, consecutive stable cycles required to accept a key level change (>=1)
TICK_DIV, 1000000, clock cycles per TICK pulse, 10 ms at 100 MHz (>=2)

Ports:
CLK  in  1  system clock, rising-edge
RST  in  1  reset, asynchronous, active-low (0 = reset)
KEY_SS  in  1  raw start/stop button, active-high, asynchronous to CLK
KEY_LAP  in  1  raw lap/clear button, active-high, asynchronous to CLK
TICK  out  1  one-cycle count enable for the time counters
CNT_CLR  out  1  one-cycle clear pulse for the time counters
LAP_HOLD  out  1  level; 1 = display frozen at lap value
RUNNING  out  1  level; 1 in RUN or LAP
STATE  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=LAP

Behaviour:
- Reset (RST=0): takes effect immediately, with no clock edge needed. State=IDLE. All outputs 0. Sync flops, debounced levels, debounce counters and prescaler all 0.
- Per key: 2-flop synchroniser (s1, s2). The debounce counter increments each cycle that s2 != db_level and clears whenever s2 == db_level. When the counter reaches DB_CYC, db_level flips and the counter clears. Press = db_level & ~db_level_d, a one-cycle pulse. Release generates nothing.
- Latency: raw key first sampled high at edge 1 and held stable -> db_level=1 after edge DB_CYC+2 -> state and all outputs update at edge DB_CYC+3.
- Bounces shorter than DB_CYC synced cycles never change db_level.
- FSM transitions, one per press pulse:
  IDLE: SS -> RUN. LAP ignored.
  RUN: SS -> PAUSE. LAP -> LAP.
  LAP: LAP -> RUN (unfreeze). SS -> PAUSE (LAP_HOLD drops to 0).
  PAUSE: SS -> RUN. LAP -> IDLE, with CNT_CLR=1 for exactly one cycle, registered with the transition.
- Simultaneous SS and LAP press in the same cycle: SS wins and LAP is discarded.
- All outputs are registered and update on the same edge as the state. LAP_HOLD=1 only in LAP. RUNNING=1 in RUN or LAP.
- Prescaler (width $clog2(TICK_DIV)):
  - In RUN/LAP it counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1, it wraps to 0 and TICK is registered 1 for one cycle.
  - TICK period is exactly TICK_DIV cycles; the first TICK follows the TICK_DIV-th edge after entry from IDLE.
  - In PAUSE it holds its value, so the partial interval is preserved on resume.
  - It is forced to 0 on entry to IDLE.
  - TICK is never 1 in IDLE or PAUSE.
- TICK continues in LAP; the counters keep running while the display is frozen.
- A key held high through reset release is debounced normally and counts as a press DB_CYC+3 edges after release.
- Reset asserted mid-operation aborts everything, including any pending TICK or CNT_CLR.

Test Plan:
Use DB_CYC=4 and TICK_DIV=5 for all scenarios.
1. Release RST, keys low for 100 cycles -> STATE=0; TICK, CNT_CLR, LAP_HOLD and RUNNING stay 0.
2. KEY_SS high for 20 cycles from edge 1 -> RUNNING=1 and STATE=1 after edge 7. TICK pulses after edges 12, 17, 22, ..., period 5, width 1.
3. Bounce: KEY_SS high 3 cycles / low 1, repeated 10 times, then low -> STATE stays 0. Then high 10 cycles -> RUN after 7 edges.
4. In RUN, press LAP -> STATE=3, LAP_HOLD=1, TICK continues. Press LAP again -> STATE=1, LAP_HOLD=0. Press LAP, then SS -> STATE=2, LAP_HOLD=0.
5. Press SS in RUN when prescaler=2 -> PAUSE, no TICK, prescaler held at 2. Press SS -> RUN, first TICK after the 3rd edge in RUN. Then PAUSE + LAP -> STATE=0, CNT_CLR high exactly 1 cycle, prescaler=0.
6. In RUN, raise both keys on the same edge -> STATE=2 only, no LAP, no CNT_CLR. Then drive RST=0 between clock edges -> all outputs 0 immediately, STATE=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: synchronises and debounces the two buttons, runs the
// IDLE/RUN/PAUSE/LAP machine and generates the tick, clear and freeze controls.
module stopwatch_ctrl #(
    parameter int unsigned DB_CYC   = 500000,
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_SS,
    input  logic       KEY_LAP,
    output logic       TICK,
    output logic       CNT_CLR,
    output logic       LAP_HOLD,
    output logic       RUNNING,
    output logic [1:0] STATE
);

    localparam int unsigned DBW = (DB_CYC < 2) ? 1 : $clog2(DB_CYC + 1);
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [PW-1:0]  P_LAST  = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // Bit 0 is the start/stop key, bit 1 the lap/clear key.
    logic [1:0]     s1_q, s1_d, s2_q, s2_d;
    logic [1:0]     db_q, db_d, dbd_q, dbd_d;
    logic [DBW-1:0] cnt_q [2];
    logic [DBW-1:0] cnt_d [2];
    logic [PW-1:0]  presc_q, presc_d;
    state_t         state_q, state_d;
    logic           tick_q, tick_d, clr_q, clr_d;
    logic           hold_q, hold_d, running_q, running_d;
    logic [1:0]     press;
    logic           ss_p, lap_p, run_now, run_next;

    always_comb begin
        s1_d  = {KEY_LAP, KEY_SS};
        s2_d  = s1_q;
        dbd_d = db_q;
        db_d  = db_q;
        for (int unsigned k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (s2_q[k] != db_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    db_d[k] = ~db_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end

        press = db_q & ~dbd_q;
        ss_p  = press[0];
        lap_p = press[1] & ~press[0];  // start/stop wins a same-cycle collision

        state_d = state_q;
        case (state_q)
            IDLE:  if (ss_p) state_d = RUN;
            RUN:   if (ss_p) state_d = PAUSE; else if (lap_p) state_d = LAP;
            LAP:   if (ss_p) state_d = PAUSE; else if (lap_p) state_d = RUN;
            PAUSE: if (ss_p) state_d = RUN;   else if (lap_p) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        clr_d     = (state_q == PAUSE) && (state_d == IDLE);
        run_now   = (state_q == RUN) || (state_q == LAP);
        run_next  = (state_d == RUN) || (state_d == LAP);
        running_d = run_next;
        hold_d    = (state_d == LAP);

        // Counting only while running on both sides of the edge keeps the
        // partial interval intact across pause and gives a full first period.
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (state_d == IDLE) begin
            presc_d = '0;
        end else if (run_now && run_next) begin
            if (presc_q == P_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            dbd_q     <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            presc_q   <= '0;
            state_q   <= IDLE;
            tick_q    <= 1'b0;
            clr_q     <= 1'b0;
            hold_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            dbd_q     <= dbd_d;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
            presc_q   <= presc_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            clr_q     <= clr_d;
            hold_q    <= hold_d;
            running_q <= running_d;
        end
    end

    assign TICK     = tick_q;
    assign CNT_CLR  = clr_q;
    assign LAP_HOLD = hold_q;
    assign RUNNING  = running_q;
    assign STATE    = state_q;

endmodule
